// File: rtl/mac_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mac_arb_pkg
// Purpose  : Shared types and constants for the MAC buffer-SRAM arbiter:
//            FSM state encoding, master identifiers, descriptor-window LSB
//            and the round-robin helper functions.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mac_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    typedef enum logic [1:0] {
        M_HST = 2'd0,
        M_GTX = 2'd1,
        M_GRX = 2'd2
    } master_id_t;

    localparam int NUM_MST  = 3;
    // Descriptor-queue windows are 64-byte aligned: adr[15:6] selects one.
    localparam int QWIN_LSB = 6;

    // Successor in the fixed hst -> gtx -> grx -> hst ring.
    function automatic master_id_t next_mst(input master_id_t m);
        case (m)
            M_HST:   next_mst = M_GTX;
            M_GTX:   next_mst = M_GRX;
            default: next_mst = M_HST;
        endcase
    endfunction

    // First requester found walking the ring from ptr (inclusive).
    function automatic master_id_t rr_pick(input logic [NUM_MST-1:0] req,
                                           input master_id_t         ptr);
        master_id_t cand;
        logic       found;
        cand    = ptr;
        found   = 1'b0;
        rr_pick = ptr;
        for (int i = 0; i < NUM_MST; i++) begin
            if (!found && req[cand]) begin
                rr_pick = cand;
                found   = 1'b1;
            end
            cand = next_mst(cand);
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/mac_mem_arb_qcnt_snoop.sv
`default_nettype none
// ============================================================================
// Module   : mac_qcnt_snoop
// Purpose  : Watches completed SRAM beats and emits one-cycle queue-occupancy
//            pulses when a beat touches the TX or RX descriptor window with
//            the top byte lane selected. Writes increment, reads decrement.
// Ports    : app_clk, reset_n      clock / async active-low reset
//            beat_ack              qualified slave ack (granted stb & ack)
//            beat_we               write enable of the acked beat
//            win_adr[9:0]          adr[15:6] of the acked beat
//            sel_msb               sel[3] of the acked beat
//            cfg_tx/rx_qbase_addr  descriptor window bases
//            tx_inc/tx_dec/rx_inc/rx_dec  registered pulses, 1 cycle after ack
// Revision : 1.0 - initial release
// ============================================================================
module mac_qcnt_snoop (
    input  logic       app_clk,
    input  logic       reset_n,
    input  logic       beat_ack,
    input  logic       beat_we,
    input  logic [9:0] win_adr,
    input  logic       sel_msb,
    input  logic [9:0] cfg_tx_qbase_addr,
    input  logic [9:0] cfg_rx_qbase_addr,
    output logic       tx_inc,
    output logic       tx_dec,
    output logic       rx_inc,
    output logic       rx_dec
);

    logic w_hit_tx;
    logic w_hit_rx;

    // Config is compared live so a base change applies to the very next ack.
    assign w_hit_tx = (win_adr == cfg_tx_qbase_addr) & sel_msb;
    assign w_hit_rx = (win_adr == cfg_rx_qbase_addr) & sel_msb;

    always_ff @(posedge app_clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_inc <= 1'b0;
            tx_dec <= 1'b0;
            rx_inc <= 1'b0;
            rx_dec <= 1'b0;
        end else begin
            tx_inc <= beat_ack &  beat_we & w_hit_tx;
            tx_dec <= beat_ack & ~beat_we & w_hit_tx;
            rx_inc <= beat_ack &  beat_we & w_hit_rx;
            rx_dec <= beat_ack & ~beat_we & w_hit_rx;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mac_mem_arb.sv
`default_nettype none
// ============================================================================
// Module   : mac_mem_arb
// Purpose  : Round-robin 3:1 Wishbone arbiter (host, GMAC TX DMA, GMAC RX DMA)
//            in front of the MAC packet/descriptor SRAM, plus descriptor-queue
//            occupancy snooping. A grant is held for the whole cyc, and an
//            idle cycle always separates two grants.
// Config   : MAC_ARB_TMO_EN - when defined, an 8-bit ack watchdog aborts a
//            transfer after TMO_CYC stalled cycles and pulses wbm_X_err_o.
//            When undefined all wbm_X_err_o are tied low.
// Ports    : app_clk, reset_n            clock / async active-low reset
//            cfg_tx/rx_qbase_addr[9:0]   descriptor windows (adr[15:6])
//            wbm_{hst,gtx,grx}_*         master-side Wishbone ports
//            wbs_mem_*                   slave-side Wishbone port
//            mac_{tx,rx}_qcnt_{inc,dec}  one-cycle occupancy pulses
// Revision : 1.0 - initial release
// ============================================================================
module mac_mem_arb
    import mac_arb_pkg::*;
#(
    parameter int AW      = 16,
    parameter int DW      = 32,
    parameter int TMO_CYC = 255
) (
    input  logic            app_clk,
    input  logic            reset_n,
    input  logic [9:0]      cfg_tx_qbase_addr,
    input  logic [9:0]      cfg_rx_qbase_addr,
    // host master
    input  logic            wbm_hst_cyc_i,
    input  logic            wbm_hst_stb_i,
    input  logic            wbm_hst_we_i,
    input  logic [AW-1:0]   wbm_hst_adr_i,
    input  logic [DW-1:0]   wbm_hst_dat_i,
    input  logic [DW/8-1:0] wbm_hst_sel_i,
    output logic [DW-1:0]   wbm_hst_dat_o,
    output logic            wbm_hst_ack_o,
    output logic            wbm_hst_err_o,
    // GMAC TX DMA master
    input  logic            wbm_gtx_cyc_i,
    input  logic            wbm_gtx_stb_i,
    input  logic            wbm_gtx_we_i,
    input  logic [AW-1:0]   wbm_gtx_adr_i,
    input  logic [DW-1:0]   wbm_gtx_dat_i,
    input  logic [DW/8-1:0] wbm_gtx_sel_i,
    output logic [DW-1:0]   wbm_gtx_dat_o,
    output logic            wbm_gtx_ack_o,
    output logic            wbm_gtx_err_o,
    // GMAC RX DMA master
    input  logic            wbm_grx_cyc_i,
    input  logic            wbm_grx_stb_i,
    input  logic            wbm_grx_we_i,
    input  logic [AW-1:0]   wbm_grx_adr_i,
    input  logic [DW-1:0]   wbm_grx_dat_i,
    input  logic [DW/8-1:0] wbm_grx_sel_i,
    output logic [DW-1:0]   wbm_grx_dat_o,
    output logic            wbm_grx_ack_o,
    output logic            wbm_grx_err_o,
    // SRAM slave
    output logic            wbs_mem_cyc_o,
    output logic            wbs_mem_stb_o,
    output logic            wbs_mem_we_o,
    output logic [AW-1:0]   wbs_mem_adr_o,
    output logic [DW-1:0]   wbs_mem_dat_o,
    output logic [DW/8-1:0] wbs_mem_sel_o,
    input  logic [DW-1:0]   wbs_mem_dat_i,
    input  logic            wbs_mem_ack_i,
    // queue occupancy pulses
    output logic            mac_tx_qcnt_inc,
    output logic            mac_tx_qcnt_dec,
    output logic            mac_rx_qcnt_inc,
    output logic            mac_rx_qcnt_dec
);

    arb_state_t         r_state;
    master_id_t         r_grant;
    master_id_t         r_rr_ptr;

    logic [NUM_MST-1:0] w_req;
    logic               w_busy;
    logic               w_g_cyc;
    logic               w_g_stb;
    logic               w_g_we;
    logic [AW-1:0]      w_g_adr;
    logic [DW-1:0]      w_g_dat;
    logic [DW/8-1:0]    w_g_sel;
    logic               w_ack;
    logic               w_tmo;
    logic [NUM_MST-1:0] w_err;

    assign w_req  = {wbm_grx_cyc_i, wbm_gtx_cyc_i, wbm_hst_cyc_i};
    assign w_busy = (r_state == BUSY);

    // ------------------------------------------------------------------
    // Granted-master request mux
    // ------------------------------------------------------------------
    always_comb begin
        w_g_cyc = 1'b0;
        w_g_stb = 1'b0;
        w_g_we  = 1'b0;
        w_g_adr = '0;
        w_g_dat = '0;
        w_g_sel = '0;
        case (r_grant)
            M_HST: begin
                w_g_cyc = wbm_hst_cyc_i;
                w_g_stb = wbm_hst_stb_i;
                w_g_we  = wbm_hst_we_i;
                w_g_adr = wbm_hst_adr_i;
                w_g_dat = wbm_hst_dat_i;
                w_g_sel = wbm_hst_sel_i;
            end
            M_GTX: begin
                w_g_cyc = wbm_gtx_cyc_i;
                w_g_stb = wbm_gtx_stb_i;
                w_g_we  = wbm_gtx_we_i;
                w_g_adr = wbm_gtx_adr_i;
                w_g_dat = wbm_gtx_dat_i;
                w_g_sel = wbm_gtx_sel_i;
            end
            M_GRX: begin
                w_g_cyc = wbm_grx_cyc_i;
                w_g_stb = wbm_grx_stb_i;
                w_g_we  = wbm_grx_we_i;
                w_g_adr = wbm_grx_adr_i;
                w_g_dat = wbm_grx_dat_i;
                w_g_sel = wbm_grx_sel_i;
            end
            default: ;
        endcase
    end

    // Slave side is quiet (all zero) whenever no grant is active, so an
    // asynchronous reset silences the bus immediately.
    assign wbs_mem_cyc_o = w_busy & w_g_cyc;
    assign wbs_mem_stb_o = w_busy & w_g_cyc & w_g_stb;
    assign wbs_mem_we_o  = w_busy & w_g_cyc & w_g_we;
    assign wbs_mem_adr_o = w_busy ? w_g_adr : '0;
    assign wbs_mem_dat_o = w_busy ? w_g_dat : '0;
    assign wbs_mem_sel_o = w_busy ? w_g_sel : '0;

    // An ack is only honoured while the granted master is strobing.
    assign w_ack = wbs_mem_stb_o & wbs_mem_ack_i;

    assign wbm_hst_ack_o = w_ack & (r_grant == M_HST);
    assign wbm_gtx_ack_o = w_ack & (r_grant == M_GTX);
    assign wbm_grx_ack_o = w_ack & (r_grant == M_GRX);

    assign wbm_hst_dat_o = (w_busy && r_grant == M_HST) ? wbs_mem_dat_i : '0;
    assign wbm_gtx_dat_o = (w_busy && r_grant == M_GTX) ? wbs_mem_dat_i : '0;
    assign wbm_grx_dat_o = (w_busy && r_grant == M_GRX) ? wbs_mem_dat_i : '0;

    assign wbm_hst_err_o = w_err[M_HST];
    assign wbm_gtx_err_o = w_err[M_GTX];
    assign wbm_grx_err_o = w_err[M_GRX];

    // ------------------------------------------------------------------
    // Arbitration FSM. BUSY ends the cycle after the granted cyc drops (or
    // a timeout), so IDLE always lasts at least one cycle between grants.
    // ------------------------------------------------------------------
    always_ff @(posedge app_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_grant  <= M_HST;
            r_rr_ptr <= M_HST;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|w_req) begin
                        r_grant <= rr_pick(w_req, r_rr_ptr);
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    if (!w_g_cyc || w_tmo) begin
                        r_state  <= IDLE;
                        r_rr_ptr <= next_mst(r_grant);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef MAC_ARB_TMO_EN
    // ------------------------------------------------------------------
    // Ack watchdog. The counter reaches TMO_CYC-1 on the TMO_CYC-th stalled
    // strobe cycle; an ack in that same cycle wins over the timeout.
    // ------------------------------------------------------------------
    localparam logic [7:0] c_TMO_LIM = 8'(TMO_CYC - 1);

    logic [7:0]         r_tmo_cnt;
    logic [NUM_MST-1:0] r_err;

    assign w_tmo = wbs_mem_stb_o & ~wbs_mem_ack_i & (r_tmo_cnt == c_TMO_LIM);
    assign w_err = r_err;

    always_ff @(posedge app_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tmo_cnt <= 8'd0;
            r_err     <= '0;
        end else begin
            r_err <= '0;
            if (!w_busy || w_ack || w_tmo) begin
                r_tmo_cnt <= 8'd0;
            end else if (wbs_mem_stb_o) begin
                r_tmo_cnt <= r_tmo_cnt + 8'd1;
            end
            if (w_tmo) begin
                r_err[r_grant] <= 1'b1;
            end
        end
    end
`else
    assign w_tmo = 1'b0;
    assign w_err = '0;
`endif

    // ------------------------------------------------------------------
    // Descriptor-queue snoop on every honoured ack, from any master.
    // ------------------------------------------------------------------
    mac_qcnt_snoop u_snoop (
        .app_clk           (app_clk),
        .reset_n           (reset_n),
        .beat_ack          (w_ack),
        .beat_we           (wbs_mem_we_o),
        .win_adr           (wbs_mem_adr_o[QWIN_LSB +: 10]),
        .sel_msb           (wbs_mem_sel_o[3]),
        .cfg_tx_qbase_addr (cfg_tx_qbase_addr),
        .cfg_rx_qbase_addr (cfg_rx_qbase_addr),
        .tx_inc            (mac_tx_qcnt_inc),
        .tx_dec            (mac_tx_qcnt_dec),
        .rx_inc            (mac_rx_qcnt_inc),
        .rx_dec            (mac_rx_qcnt_dec)
    );

endmodule
`default_nettype wire
